mccu: RTL and testbench
=======================

Name: mccu

Overview:
- Maximum-Contention Control Unit: per-core budget (quota) tracker for a multicore SoC.
- Each cycle, each core's remaining quota is reduced by the weighted sum of that core's active contention events.
- Raises a per-core interrupt when a core's quota is exhausted.
- Sits beside the cores' event/PMU signals; quotas and weights are supplied by a configuration/register wrapper.

Parameters:
- DATA_WIDTH, 32: width of quota input and remaining-quota output.
- WEIGHTS_WIDTH, 7: width of each event weight.
- N_CORES, 1: number of monitored cores (≥1).
- CORE_EVENTS, 1: number of event lines per core (≥1).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rstn_i  in  1  reset; asynchronous, active-low.
- enable_i  in  1  1 = count/decrement mode; 0 = load/hold-config mode.
- events_i  in  [CORE_EVENTS-1:0] x N_CORES (unpacked array [0:N_CORES-1])  per-core event levels.
- quota_i  in  [DATA_WIDTH-1:0] x N_CORES  per-core quota to load.
- events_weights_i  in  [WEIGHTS_WIDTH-1:0] x N_CORES x CORE_EVENTS  weight of each event of each core.
- quota_o  out  [DATA_WIDTH-1:0] x N_CORES  per-core remaining quota (registered).
- interruption_quota_o  out  1 x N_CORES (unpacked [N_CORES-1:0])  per-core quota-exhausted flag.

Behaviour:
- One DATA_WIDTH quota register per core; quota_o[c] drives it directly.
- Reset (rstn_i low, asynchronous):
  - all quota registers clear to 0 immediately; quota_o = 0.
  - interruption_quota_o is therefore 1 for every core (quota == 0).
  - reset mid-operation discards the remaining quota; no other state exists.
- Weighted sum per core:
  - sum[c] = Σ over e of (events_i[c][e] ? events_weights_i[c][e] : 0).
  - combinational; width WEIGHTS_WIDTH + $clog2(CORE_EVENTS+1), zero-extended to DATA_WIDTH for the compare/subtract.
- enable_i = 0: quota_reg[c] <= quota_i[c] every rising edge (1-cycle load latency); events are ignored.
- enable_i = 1: quota_reg[c] <= (quota_reg[c] > sum[c]) ? quota_reg[c] - sum[c] : 0.
  - Saturating subtract; never wraps below 0.
  - quota_i is ignored.
  - Events are level-sensitive: an event held high for N cycles is charged N times.
  - Simultaneous events on one core are summed in the same cycle.
  - Cores are fully independent.
- interruption_quota_o[c]:
  - combinational: 1 when quota_reg[c] == 0, or when enable_i = 1 and sum[c] ≥ quota_reg[c] (exhaustion this cycle); else 0.
  - Not sticky; deasserts when a nonzero quota is reloaded with enable_i = 0.
  - Zero-weight events never change quota.
- Enable transitions:
  - 0→1: the first decrement uses the last loaded value.
  - 1→0: the next edge reloads quota_i, overwriting the consumed budget.
- Width rule: a quota_i wider than DATA_WIDTH is the wrapper's concern; the block uses the low DATA_WIDTH bits.

Test Plan:
1. Reset, then hold rstn_i = 1, enable_i = 0 → quota_o[0] = 0, interruption_quota_o[0] = 1.
2. enable_i = 0, quota_i[0] = 200, one clock → quota_o[0] = 200, interrupt 0; then change quota_i to 150, one clock → 150.
3. Load 200, weight[0][0] = 10, events_i[0][0] = 1 with enable_i = 0 for several clocks → quota_o stays 200.
4. Same setup, set enable_i = 1, one clock → quota_o = 190; hold the event 3 more clocks → 160; drop the event → holds 160.
5. Load 15, weight 10, enable with event held → 5 after 1 clock (interrupt 1 in that cycle since 10 ≥ 5), then 0 after 2 clocks (no wrap), interrupt stays 1.
6. CORE_EVENTS = 2, weights 3 and 4, both events high, quota 100 enabled, one clock → 93; assert rstn_i low asynchronously mid-cycle → quota_o = 0 and interrupt = 1 immediately.

Source files
------------

// File: rtl/mccu.sv
// Maximum-contention control unit: per-core quota tracker.
// Each core's budget drains by the weighted sum of its active events.
module mccu #(
    parameter int DATA_WIDTH    = 32,
    parameter int WEIGHTS_WIDTH = 7,
    parameter int N_CORES       = 1,
    parameter int CORE_EVENTS   = 1
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     enable_i,
    input  logic [CORE_EVENTS-1:0]   events_i [0:N_CORES-1],
    input  logic [DATA_WIDTH-1:0]    quota_i [0:N_CORES-1],
    input  logic [WEIGHTS_WIDTH-1:0] events_weights_i [0:N_CORES-1][0:CORE_EVENTS-1],
    output logic [DATA_WIDTH-1:0]    quota_o [0:N_CORES-1],
    output logic                     interruption_quota_o [N_CORES-1:0]
);

    // Wide enough to add every weight of a core without overflow.
    localparam int SUM_WIDTH = WEIGHTS_WIDTH + $clog2(CORE_EVENTS + 1);

    logic [SUM_WIDTH-1:0]  sum       [0:N_CORES-1];
    logic [DATA_WIDTH-1:0] sum_ext   [0:N_CORES-1];
    logic [DATA_WIDTH-1:0] quota_reg [0:N_CORES-1];

    // Weighted sum of the events asserted this cycle, per core.
    always_comb begin
        for (int c = 0; c < N_CORES; c++) begin
            sum[c] = '0;
            for (int e = 0; e < CORE_EVENTS; e++) begin
                if (events_i[c][e]) begin
                    sum[c] = sum[c] + SUM_WIDTH'(events_weights_i[c][e]);
                end
            end
            sum_ext[c] = DATA_WIDTH'(sum[c]);
        end
    end

    // Load quotas while disabled, otherwise drain with a floor at zero.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < N_CORES; c++) begin
                quota_reg[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CORES; c++) begin
                if (!enable_i) begin
                    quota_reg[c] <= quota_i[c];
                end else if (quota_reg[c] > sum_ext[c]) begin
                    quota_reg[c] <= quota_reg[c] - sum_ext[c];
                end else begin
                    quota_reg[c] <= '0;
                end
            end
        end
    end

    // Flag a core already at zero or about to be drained this cycle.
    always_comb begin
        for (int c = 0; c < N_CORES; c++) begin
            quota_o[c] = quota_reg[c];
            interruption_quota_o[c] = (quota_reg[c] == '0) ||
                                      (enable_i && (sum_ext[c] >= quota_reg[c]));
        end
    end

endmodule

// File: tb/tb_mccu.sv
// Scoreboard bench for mccu: driver pushes expected outputs,
// monitor pops and compares once per cycle.
module tb_mccu;

    localparam int DW = 32;
    localparam int WW = 7;
    localparam int NC = 2;
    localparam int CE = 2;

    typedef struct packed {
        logic [NC-1:0][DW-1:0] q;
        logic [NC-1:0]         irq;
    } exp_t;

    logic          clk;
    logic          rstn_i;
    logic          enable_i;
    logic [CE-1:0] events_i [0:NC-1];
    logic [DW-1:0] quota_i [0:NC-1];
    logic [WW-1:0] weights_i [0:NC-1][0:CE-1];
    logic [DW-1:0] quota_o [0:NC-1];
    logic          irq_o [NC-1:0];

    logic          s_rstn;
    logic          s_en;
    logic [CE-1:0] s_ev [0:NC-1];
    logic [DW-1:0] s_q [0:NC-1];
    logic [WW-1:0] s_w [0:NC-1][0:CE-1];

    longint mq [0:NC-1];
    exp_t   sb [$];
    int     tests;
    int     fails;

    mccu #(
        .DATA_WIDTH(DW),
        .WEIGHTS_WIDTH(WW),
        .N_CORES(NC),
        .CORE_EVENTS(CE)
    ) dut (
        .clk_i(clk),
        .rstn_i(rstn_i),
        .enable_i(enable_i),
        .events_i(events_i),
        .quota_i(quota_i),
        .events_weights_i(weights_i),
        .quota_o(quota_o),
        .interruption_quota_o(irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: budget arithmetic on plain integers.
    task automatic model_step();
        exp_t   x;
        longint s;
        if (!rstn_i) begin
            for (int c = 0; c < NC; c++) mq[c] = 0;
        end
        for (int c = 0; c < NC; c++) begin
            s = 0;
            for (int e = 0; e < CE; e++) begin
                if (events_i[c][e]) s += weights_i[c][e];
            end
            x.q[c]   = DW'(mq[c]);
            x.irq[c] = (mq[c] == 0) || (enable_i && s >= mq[c]);
            if (!rstn_i)        mq[c] = 0;
            else if (!enable_i) mq[c] = quota_i[c];
            else                mq[c] = (mq[c] > s) ? mq[c] - s : 0;
        end
        sb.push_back(x);
    endtask

    task automatic cycle();
        @(negedge clk);
        rstn_i   = s_rstn;
        enable_i = s_en;
        for (int c = 0; c < NC; c++) begin
            events_i[c] = s_ev[c];
            quota_i[c]  = s_q[c];
            for (int e = 0; e < CE; e++) weights_i[c][e] = s_w[c][e];
        end
        model_step();
    endtask

    task automatic async_reset();
        @(negedge clk);
        #1;
        rstn_i = 1'b0;
        s_rstn = 1'b0;
        model_step();
    endtask

    task automatic clear_stage();
        s_en = 1'b0;
        for (int c = 0; c < NC; c++) begin
            s_ev[c] = '0;
            s_q[c]  = '0;
            for (int e = 0; e < CE; e++) s_w[c][e] = '0;
        end
    endtask

    // Monitor: one comparison set per cycle while expectations are queued.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                for (int c = 0; c < NC; c++) begin
                    tests++;
                    if (quota_o[c] !== x.q[c]) begin
                        fails++;
                        $display("FAIL quota_o[%0d] t=%0t got %0d expected %0d",
                                 c, $time, quota_o[c], x.q[c]);
                    end
                    tests++;
                    if (irq_o[c] !== x.irq[c]) begin
                        fails++;
                        $display("FAIL irq[%0d] t=%0t got %b expected %b",
                                 c, $time, irq_o[c], x.irq[c]);
                    end
                end
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        rstn_i = 1'b0;
        enable_i = 1'b0;
        for (int c = 0; c < NC; c++) begin
            mq[c] = 0;
            events_i[c] = '0;
            quota_i[c] = '0;
            for (int e = 0; e < CE; e++) weights_i[c][e] = '0;
        end
        clear_stage();

        // Reset, then idle with enable low.
        s_rstn = 1'b0;
        cycle();
        cycle();
        s_rstn = 1'b1;
        cycle();
        cycle();

        // Loads with 1-cycle latency.
        s_q[0] = 200;
        s_q[1] = 77;
        cycle();
        cycle();
        s_q[0] = 150;
        cycle();
        cycle();

        // Events ignored while loading.
        s_q[0] = 200;
        s_w[0][0] = 10;
        s_ev[0] = 2'b01;
        repeat (4) cycle();

        // Drain 10 per cycle, then hold when event drops.
        s_en = 1'b1;
        repeat (4) cycle();
        s_ev[0] = 2'b00;
        repeat (2) cycle();

        // Saturation at zero.
        s_en = 1'b0;
        s_q[0] = 15;
        s_ev[0] = 2'b01;
        cycle();
        s_en = 1'b1;
        repeat (4) cycle();

        // Two events summed, core 1 independent, then async reset.
        s_en = 1'b0;
        s_q[0] = 100;
        s_q[1] = 50;
        s_w[0][0] = 3;
        s_w[0][1] = 4;
        s_w[1][0] = 0;
        s_w[1][1] = 9;
        s_ev[0] = 2'b11;
        s_ev[1] = 2'b01;
        cycle();
        s_en = 1'b1;
        repeat (2) cycle();
        async_reset();
        cycle();
        s_rstn = 1'b1;
        cycle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset();
                cycle();
                s_rstn = 1'b1;
            end
            s_en = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < NC; c++) begin
                s_ev[c] = CE'($urandom);
                s_q[c] = ($urandom_range(0, 7) == 0) ? DW'($urandom)
                                                      : DW'($urandom_range(0, 400));
                for (int e = 0; e < CE; e++) begin
                    s_w[c][e] = ($urandom_range(0, 4) == 0) ? '0 : WW'($urandom);
                end
            end
            cycle();
        end

        clear_stage();
        cycle();
        repeat (3) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
